// File: rtl/day7_week_tracker.sv
// day7_week_tracker: consumer of a binary-coded mod-7 day counter.
// This block samples the code {y3,y2,y1}, decodes it to a one-hot day,
// detects the 6->0 wrap, counts weeks modulo WEEKS and raises sticky
// flags for illegal codes and sequence breaks.
// Optional build macro SEG7_OUT_EN adds a registered 7-segment output
// 'seg' (active high, seg[6]=g ... seg[0]=a) that is aligned with day_oh.
module day7_week_tracker #(
  parameter int WEEKS = 4,
  parameter int WK_W  = 2
) (
  input  logic            Cp,
  input  logic            R,
  input  logic            y1,
  input  logic            y2,
  input  logic            y3,
  output logic [6:0]      day_oh,
  output logic            wrap,
  output logic [WK_W-1:0] wk,
  output logic            wk_carry,
  output logic            err_code,
`ifdef SEG7_OUT_EN
  output logic            err_seq,
  output logic [6:0]      seg
`else
  output logic            err_seq
`endif
);

  localparam logic [WK_W-1:0] WK_LAST = WK_W'(WEEKS - 1);

  // Code that should follow p. Code 7 is followed by 0.
  function automatic logic [2:0] next_day(input logic [2:0] p);
    if (p == 3'd6) begin
      next_day = 3'd0;
    end else begin
      next_day = p + 3'd1;
    end
  endfunction

  // One-hot decode of a day code. Code 7 gives all zeros.
  function automatic logic [6:0] day_decode(input logic [2:0] c);
    case (c)
      3'd0:    day_decode = 7'b000_0001;
      3'd1:    day_decode = 7'b000_0010;
      3'd2:    day_decode = 7'b000_0100;
      3'd3:    day_decode = 7'b000_1000;
      3'd4:    day_decode = 7'b001_0000;
      3'd5:    day_decode = 7'b010_0000;
      3'd6:    day_decode = 7'b100_0000;
      default: day_decode = 7'b000_0000;
    endcase
  endfunction

`ifdef SEG7_OUT_EN
  // 7-segment pattern for a day code. Code 7 is shown as a dash.
  function automatic logic [6:0] seg_decode(input logic [2:0] c);
    case (c)
      3'd0:    seg_decode = 7'h3F;
      3'd1:    seg_decode = 7'h06;
      3'd2:    seg_decode = 7'h5B;
      3'd3:    seg_decode = 7'h4F;
      3'd4:    seg_decode = 7'h66;
      3'd5:    seg_decode = 7'h6D;
      3'd6:    seg_decode = 7'h7D;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  logic [6:0] seg_d, seg_q;
`endif

  logic [2:0]      cur_d, cur_q;
  logic [2:0]      prv_d, prv_q;
  logic [1:0]      vld_d, vld_q;
  logic [6:0]      day_oh_d, day_oh_q;
  logic            wrap_d, wrap_q;
  logic [WK_W-1:0] wk_d, wk_q;
  logic            wk_carry_d, wk_carry_q;
  logic            err_code_d, err_code_q;
  logic            err_seq_d, err_seq_q;
  logic            wrap_cond_s;

  // Next-state logic for the sampling stage and the decode/count stage.
  always_comb begin
    cur_d       = {y3, y2, y1};
    prv_d       = cur_q;
    vld_d       = {vld_q[0], 1'b1};
    day_oh_d    = day_decode(cur_q);
    wrap_cond_s = vld_q[1] & (prv_q == 3'd6) & (cur_q == 3'd0);
    wrap_d      = wrap_cond_s;
    wk_d        = wk_q;
    wk_carry_d  = 1'b0;
    if (wrap_cond_s) begin
      wk_carry_d = (wk_q == WK_LAST);
      if (wk_q == WK_LAST) begin
        wk_d = {WK_W{1'b0}};
      end else begin
        wk_d = wk_q + WK_W'(1);
      end
    end else begin
      wk_d = wk_q;
    end
    err_code_d = err_code_q | (cur_q == 3'd7);
    err_seq_d  = err_seq_q | (vld_q[1] & (cur_q != next_day(prv_q)));
`ifdef SEG7_OUT_EN
    seg_d      = seg_decode(cur_q);
`endif
  end

  // State registers; R clears everything immediately.
  always_ff @(posedge Cp or negedge R) begin
    if (!R) begin
      cur_q      <= 3'd0;
      prv_q      <= 3'd0;
      vld_q      <= 2'b00;
      day_oh_q   <= 7'd0;
      wrap_q     <= 1'b0;
      wk_q       <= {WK_W{1'b0}};
      wk_carry_q <= 1'b0;
      err_code_q <= 1'b0;
      err_seq_q  <= 1'b0;
`ifdef SEG7_OUT_EN
      seg_q      <= 7'h00;
`endif
    end else begin
      cur_q      <= cur_d;
      prv_q      <= prv_d;
      vld_q      <= vld_d;
      day_oh_q   <= day_oh_d;
      wrap_q     <= wrap_d;
      wk_q       <= wk_d;
      wk_carry_q <= wk_carry_d;
      err_code_q <= err_code_d;
      err_seq_q  <= err_seq_d;
`ifdef SEG7_OUT_EN
      seg_q      <= seg_d;
`endif
    end
  end

  assign day_oh   = day_oh_q;
  assign wrap     = wrap_q;
  assign wk       = wk_q;
  assign wk_carry = wk_carry_q;
  assign err_code = err_code_q;
  assign err_seq  = err_seq_q;
`ifdef SEG7_OUT_EN
  assign seg      = seg_q;
`endif

endmodule
